// File: rtl/axil_pkg.sv
// Shared AXI4-Lite helpers: response codes, address-LSB calculation and byte-strobe merge.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int addrlsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Sized for the widest supported bus; narrower callers pad and truncate.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  strb);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_regfile_decode.sv
// Byte address to register index, in-range flag and one-hot register select.
module axil_regfile_decode
    import axil_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int ADDRLSB  = 2,
    parameter int NUM_REGS = 8
) (
    input  logic [ADDR_W-1:0]         addr,
    output logic [ADDR_W-ADDRLSB-1:0] idx,
    output logic                      in_range,
    output logic [NUM_REGS-1:0]       sel
);

    logic unused_lsb;

    assign idx        = addr[ADDR_W-1:ADDRLSB];
    assign in_range   = int'(idx) < NUM_REGS;
    assign unused_lsb = ^addr[ADDRLSB-1:0];

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            sel[i] = in_range && (int'(idx) == i);
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// Parametrised AXI4-Lite register file with strobe merge, per-register write pulses and parallel outputs.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_regfile
    import axil_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = 6,
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS         = 8,
    parameter logic [C_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    output logic [1:0]                         S_AXI_BRESP,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic [NUM_REGS*C_AXI_DATA_WIDTH-1:0] o_regs,
    output logic [NUM_REGS-1:0]                o_wr_stb
);

    localparam int DW      = C_AXI_DATA_WIDTH;
    localparam int ADDRLSB = addrlsb(DW);
    localparam int IDXW    = C_AXI_ADDR_WIDTH - ADDRLSB;

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]         wr_stb_q, wr_stb_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [DW-1:0]               rdata_q, rdata_d;

    logic [IDXW-1:0]     aw_idx, ar_idx;
    logic                aw_in_range, ar_in_range;
    logic [NUM_REGS-1:0] aw_sel, ar_sel;
    logic                wr_go, rd_go;
    logic                unused_ok;

    axil_regfile_decode #(
        .ADDR_W(C_AXI_ADDR_WIDTH), .ADDRLSB(ADDRLSB), .NUM_REGS(NUM_REGS)
    ) u_aw_dec (
        .addr(S_AXI_AWADDR), .idx(aw_idx), .in_range(aw_in_range), .sel(aw_sel)
    );

    axil_regfile_decode #(
        .ADDR_W(C_AXI_ADDR_WIDTH), .ADDRLSB(ADDRLSB), .NUM_REGS(NUM_REGS)
    ) u_ar_dec (
        .addr(S_AXI_ARADDR), .idx(ar_idx), .in_range(ar_in_range), .sel(ar_sel)
    );

    // Address and data are only ever taken together, so one ready serves both.
    assign wr_go         = S_AXI_AWVALID && S_AXI_WVALID && (!bvalid_q || S_AXI_BREADY);
    assign rd_go         = S_AXI_ARVALID && (!rvalid_q || S_AXI_RREADY);
    assign S_AXI_AWREADY = wr_go;
    assign S_AXI_WREADY  = wr_go;
    assign S_AXI_ARREADY = !rvalid_q || S_AXI_RREADY;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_idx, ar_idx};

    always_comb begin
        regs_d   = regs_q;
        wr_stb_d = '0;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (wr_go) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (aw_sel[i]) begin
                    regs_d[i] = DW'(strb_merge(64'(regs_q[i]), 64'(S_AXI_WDATA), 8'(S_AXI_WSTRB)));
                end
            end
            wr_stb_d = aw_sel;
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : OOR_RESP;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample regs_q, so a same-cycle write is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rd_go) begin
            rdata_d = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_sel[i]) rdata_d = regs_q[i];
            end
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : OOR_RESP;
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs_q   <= {NUM_REGS{RESET_VALUE}};
            wr_stb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_stb_q <= wr_stb_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = rdata_q;
    assign o_regs       = regs_q;
    assign o_wr_stb     = wr_stb_q;

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed table, handshake corner cases and random traffic vs. a model.
module tb_axil_regfile;

    localparam int NREG = 6;
    localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [5:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NREG*32-1:0] o_regs;
    logic [NREG-1:0] o_wr_stb;

    int checks = 0, errors = 0;
    logic [31:0] model [NREG];

    always #5 clk = ~clk;

    axil_regfile #(
        .C_AXI_ADDR_WIDTH(6), .C_AXI_DATA_WIDTH(32), .NUM_REGS(NREG), .RESET_VALUE(RV)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
        .o_regs(o_regs), .o_wr_stb(o_wr_stb)
    );

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [5:0] a);
        return int'(a[5:2]) < NREG;
    endfunction

    function automatic logic [31:0] model_rd(input logic [5:0] a);
        return in_rng(a) ? model[a[5:2]] : 32'h0;
    endfunction

    function automatic void model_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        if (in_rng(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) model[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [NREG*32-1:0] exp_regs();
        logic [NREG*32-1:0] r;
        for (int i = 0; i < NREG; i++) r[i*32 +: 32] = model[i];
        return r;
    endfunction

    function automatic logic [NREG-1:0] exp_stb(input logic [5:0] a);
        logic [NREG-1:0] s = '0;
        if (in_rng(a)) s[a[5:2]] = 1'b1;
        return s;
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input string nm);
        int n = 0;
        @(negedge clk);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s; bready = 1;
        #1;
        while (!awready && n < 20) begin @(negedge clk); #1; n++; end
        check({nm, "_accept"}, awready, 1'b1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        model_wr(a, d, s);
        check({nm, "_bvalid"}, bvalid, 1'b1);
        check({nm, "_bresp"}, bresp, exp_resp);
        check({nm, "_stb"}, o_wr_stb, exp_stb(a));
        check({nm, "_regs"}, o_regs, exp_regs());
        @(negedge clk);
        check({nm, "_bclr"}, {bvalid, o_wr_stb}, '0);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_resp, input string nm);
        int n = 0;
        @(negedge clk);
        arvalid = 1; araddr = a; rready = 1;
        #1;
        while (!arready && n < 20) begin @(negedge clk); #1; n++; end
        check({nm, "_accept"}, arready, 1'b1);
        @(negedge clk);
        arvalid = 0;
        check({nm, "_rvalid"}, rvalid, 1'b1);
        check({nm, "_rdata"}, rdata, exp_d);
        check({nm, "_rresp"}, rresp, exp_resp);
        @(negedge clk);
        check({nm, "_rclr"}, rvalid, 1'b0);
    endtask

    typedef struct {
        bit          is_rd;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        for (int i = 0; i < NREG; i++) model[i] = RV;

        vecs.push_back('{1, 6'h00, 32'h0,        4'h0, RV,           2'b00});
        vecs.push_back('{0, 6'h04, 32'hDEADBEEF, 4'hF, 32'h0,        2'b00});
        vecs.push_back('{0, 6'h04, 32'h000000AA, 4'h1, 32'h0,        2'b00});
        vecs.push_back('{1, 6'h04, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00});
        vecs.push_back('{1, 6'h06, 32'h0,        4'h0, 32'hDEADBEAA, 2'b00});
        vecs.push_back('{0, 6'h1C, 32'h12345678, 4'hF, 32'h0,        OOR});
        vecs.push_back('{1, 6'h1C, 32'h0,        4'h0, 32'h0,        OOR});
        vecs.push_back('{0, 6'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        OOR});
        vecs.push_back('{1, 6'h14, 32'h0,        4'h0, RV,           2'b00});
        vecs.push_back('{0, 6'h14, 32'h12345678, 4'h6, 32'h0,        2'b00});
        vecs.push_back('{1, 6'h14, 32'h0,        4'h0, 32'hA5345600, 2'b00});
        vecs.push_back('{0, 6'h00, 32'hFFFFFFFF, 4'h0, 32'h0,        2'b00});
        vecs.push_back('{1, 6'h00, 32'h0,        4'h0, RV,           2'b00});
        vecs.push_back('{1, 6'h3C, 32'h0,        4'h0, 32'h0,        OOR});

        repeat (3) @(negedge clk);
        check("rst_valids", {bvalid, rvalid, o_wr_stb}, '0);
        check("rst_regs", o_regs, exp_regs());
        check("rst_resp_data", {bresp, rresp, rdata}, '0);
        rst_n = 1;

        foreach (vecs[k]) begin
            if (vecs[k].is_rd)
                do_read(vecs[k].addr, vecs[k].exp_rdata, vecs[k].exp_resp, $sformatf("vec%0d", k));
            else
                do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].exp_resp, $sformatf("vec%0d", k));
        end
        check("regs_slice1", o_regs[63:32], 32'hDEADBEAA);

        // Address without data must not be accepted.
        @(negedge clk);
        awvalid = 1; awaddr = 6'h0C; wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 0;
        for (int c = 0; c < 5; c++) begin #1; check("aw_only_ready", {awready, wready}, 2'b00); @(negedge clk); end
        wvalid = 1; #1;
        check("aw_w_ready", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 0; wvalid = 0; model_wr(6'h0C, 32'h0BADF00D, 4'hF);
        check("aw_w_bvalid", bvalid, 1'b1);
        check("aw_w_regs", o_regs, exp_regs());
        @(negedge clk);

        // Write response backpressure.
        bready = 0; awvalid = 1; wvalid = 1; awaddr = 6'h10; wdata = 32'h11111111; wstrb = 4'hF; #1;
        check("bp_first_ready", awready, 1'b1);
        @(negedge clk);
        model_wr(6'h10, 32'h11111111, 4'hF);
        wdata = 32'h22222222; #1;
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_ready", awready, 1'b0);
            check("bp_hold_bvalid", bvalid, 1'b1);
            check("bp_hold_regs", o_regs, exp_regs());
            @(negedge clk); #1;
        end
        bready = 1; #1;
        check("bp_release_ready", awready, 1'b1);
        @(negedge clk);
        awvalid = 0; wvalid = 0; model_wr(6'h10, 32'h22222222, 4'hF);
        check("bp_second_bvalid", bvalid, 1'b1);
        check("bp_second_stb", o_wr_stb, exp_stb(6'h10));
        check("bp_second_regs", o_regs, exp_regs());
        @(negedge clk);

        // Read response backpressure.
        rready = 0; arvalid = 1; araddr = 6'h10;
        @(negedge clk);
        araddr = 6'h0C; #1;
        for (int c = 0; c < 3; c++) begin
            check("rbp_hold_ready", arready, 1'b0);
            check("rbp_hold_data", {rvalid, rdata, rresp}, {1'b1, 32'h22222222, 2'b00});
            @(negedge clk); #1;
        end
        rready = 1; #1;
        check("rbp_release_ready", arready, 1'b1);
        @(negedge clk);
        arvalid = 0;
        check("rbp_second_data", {rvalid, rdata}, {1'b1, model_rd(6'h0C)});
        @(negedge clk);

        // Same-cycle read and write of one register.
        do_write(6'h08, 32'h11, 4'hF, 2'b00, "pre_same");
        @(negedge clk);
        awvalid = 1; wvalid = 1; awaddr = 6'h08; wdata = 32'h22; wstrb = 4'hF;
        arvalid = 1; araddr = 6'h08; #1;
        check("same_ready", {awready, arready}, 2'b11);
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0; model_wr(6'h08, 32'h22, 4'hF);
        check("same_old_rdata", {rvalid, rdata}, {1'b1, 32'h11});
        check("same_regs", o_regs, exp_regs());
        do_read(6'h08, 32'h22, 2'b00, "same_after");

        // Reset while a write response is pending.
        @(negedge clk);
        bready = 0; awvalid = 1; wvalid = 1; awaddr = 6'h08; wdata = 32'h33; wstrb = 4'hF;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        check("rst_mid_bvalid", bvalid, 1'b1);
        #2 rst_n = 0;
        #1;
        for (int i = 0; i < NREG; i++) model[i] = RV;
        check("rst_mid_bclr", {bvalid, rvalid, o_wr_stb}, '0);
        check("rst_mid_regs", o_regs, exp_regs());
        @(negedge clk);
        rst_n = 1; bready = 1;

        for (int t = 0; t < 150; t++) begin
            logic [5:0] a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0)
                do_read(a, model_rd(a), in_rng(a) ? 2'b00 : OOR, "rnd_rd");
            else
                do_write(a, $urandom, 4'($urandom_range(0, 15)), in_rng(a) ? 2'b00 : OOR, "rnd_wr");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
